// File: rtl/vga_timing_monitor_if.sv
// Sampled VGA sync/video inputs and the recovered timing/lock outputs of vga_timing_monitor.
// master drives the sync stream and err_clr; slave is the monitor.
interface vga_timing_monitor_if;
  logic       pix_en;
  logic       hsync_in;
  logic       vsync_in;
  logic       bright_in;
  logic       err_clr;
  logic       locked;
  logic       pixel_valid;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;
  logic [9:0] act_width;
  logic [9:0] act_height;
  logic [4:0] err_flags;
  logic [7:0] err_count;

  modport master (
    output pix_en, hsync_in, vsync_in, bright_in, err_clr,
    input  locked, pixel_valid, x, y, frame_start, act_width, act_height, err_flags, err_count
  );

  modport slave (
    input  pix_en, hsync_in, vsync_in, bright_in, err_clr,
    output locked, pixel_valid, x, y, frame_start, act_width, act_height, err_flags, err_count
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// VGA timing monitor: recovers x/y, measures line/frame/active geometry, checks timing and tracks lock.
// One pixel-strobe latency, no backpressure, holds while pix_en=0; VGA_MON_ACT_CHECK_EN adds line-width consistency.
module vga_timing_monitor #(
  parameter int H_TOTAL = 800,
  parameter int H_SYNC  = 96,
  parameter int V_TOTAL = 525,
  parameter int V_SYNC  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_timing_monitor_if.slave  mon
);
  typedef enum logic [1:0] {SEEK = 2'd0, ACQ = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  H_SYNC_W  = 10'(H_SYNC);
  localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
  localparam logic [9:0]  V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0]  SAT10     = 10'h3ff;

  state_t     state_q, state_d;
  logic       hs_s_q, vs_s_q, br_s_q;
  logic       hs_p_q, vs_p_q, br_p_q;
  logic [9:0] hcnt_q, hcnt_d, hw_q, hw_d, vcnt_q, vcnt_d, vw_q, vw_d;
  logic [9:0] x_q, x_d, y_q, y_d, brcnt_q, brcnt_d, brcnt_base;
  logic [9:0] act_width_q, act_width_d, act_height_q, act_height_d, w_cur;
  logic       frame_ok_q, frame_ok_d;
  logic       locked_q, locked_d, pixel_valid_q, pixel_valid_d, frame_start_q, frame_start_d;
  logic [4:0] err_flags_q, err_flags_d, err, err_act;
  logic [7:0] err_count_q, err_count_d;
  logic       clr_pend_q, clr_pend_d, clear_now, any_err;
  logic       hs_fall, hs_rise, vs_fall, vs_rise, br_rise, br_fall;
`ifdef VGA_MON_ACT_CHECK_EN
  logic [9:0] ref_w_q, ref_w_d;
  logic       ref_vld_q, ref_vld_d, ref_vld_base;
`endif

  // Edges compare the registered sample k against its predecessor k-1.
  assign hs_fall = hs_p_q & ~hs_s_q;
  assign hs_rise = ~hs_p_q & hs_s_q;
  assign vs_fall = vs_p_q & ~vs_s_q;
  assign vs_rise = ~vs_p_q & vs_s_q;
  assign br_rise = ~br_p_q & br_s_q;
  assign br_fall = br_p_q & ~br_s_q;

  always_comb begin
    err           = '0;
    hcnt_d        = hs_fall ? 10'd0 : ((hcnt_q == SAT10) ? hcnt_q : hcnt_q + 10'd1);
    hw_d          = hw_q;
    vcnt_d        = vcnt_q;
    vw_d          = vw_q;
    x_d           = x_q;
    y_d           = y_q;
    w_cur         = (x_q == SAT10) ? x_q : x_q + 10'd1;
    act_width_d   = br_fall ? w_cur : act_width_q;
    act_height_d  = vs_fall ? brcnt_q : act_height_q;
    brcnt_base    = vs_fall ? 10'd0 : brcnt_q;
    brcnt_d       = brcnt_base;
    state_d       = state_q;
    frame_ok_d    = frame_ok_q;
    err_count_d   = err_count_q;
    clear_now     = mon.err_clr | clr_pend_q;
    clr_pend_d    = mon.pix_en ? 1'b0 : clr_pend_q | mon.err_clr;

    if ((hs_fall && ({1'b0, hcnt_q} + 11'd1 != H_TOTAL_W)) || hcnt_q == SAT10) err[0] = 1'b1;
    if (hs_fall) hw_d = 10'd1;
    else if (!hs_s_q && hw_q != SAT10) hw_d = hw_q + 10'd1;
    if (hs_rise && hw_q != H_SYNC_W) err[1] = 1'b1;

    // A coincident hsync fall is subsumed by the frame restart.
    if (vs_fall) vcnt_d = 10'd0;
    else if (hs_fall && vcnt_q != SAT10) vcnt_d = vcnt_q + 10'd1;
    if (vs_fall && ({1'b0, vcnt_q} + 11'd1 != V_TOTAL_W)) err[2] = 1'b1;
    if (vs_fall) vw_d = 10'd1;
    else if (hs_fall && !vs_s_q && vw_q != SAT10) vw_d = vw_q + 10'd1;
    if (vs_rise && vw_q != V_SYNC_W) err[3] = 1'b1;

    if (br_rise) x_d = 10'd0;
    else if (br_s_q && x_q != SAT10) x_d = x_q + 10'd1;
    if (br_rise) begin
      y_d     = brcnt_base;
      brcnt_d = (brcnt_base == SAT10) ? brcnt_base : brcnt_base + 10'd1;
    end

`ifdef VGA_MON_ACT_CHECK_EN
    ref_vld_base = vs_fall ? 1'b0 : ref_vld_q;
    ref_vld_d    = ref_vld_base;
    ref_w_d      = ref_w_q;
    if (br_fall) begin
      if (!ref_vld_base) begin
        ref_w_d   = w_cur;
        ref_vld_d = 1'b1;
      end else if (w_cur != ref_w_q) begin
        err[4] = 1'b1;
      end
    end
`endif

    err_act = (state_q == SEEK) ? 5'd0 : err;
    any_err = |err_act;

    case (state_q)
      SEEK: begin
        if (vs_fall) begin
          state_d    = ACQ;
          frame_ok_d = 1'b1;
        end
      end
      ACQ: begin
        if (vs_fall) begin
          if (frame_ok_q && !any_err) state_d = LOCKED;
          frame_ok_d = 1'b1;
        end else if (any_err) begin
          frame_ok_d = 1'b0;
        end
      end
      LOCKED: begin
        if (any_err) begin
          state_d     = SEEK;
          err_count_d = (err_count_q == 8'hff) ? err_count_q : err_count_q + 8'd1;
        end
      end
      default: state_d = SEEK;
    endcase

    err_flags_d   = (clear_now ? 5'd0 : err_flags_q) | err_act;
    locked_d      = (state_d == LOCKED);
    pixel_valid_d = locked_d & br_s_q;
    frame_start_d = vs_fall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEEK;
      hs_s_q        <= 1'b1;
      vs_s_q        <= 1'b1;
      br_s_q        <= 1'b0;
      hs_p_q        <= 1'b1;
      vs_p_q        <= 1'b1;
      br_p_q        <= 1'b0;
      hcnt_q        <= '0;
      hw_q          <= '0;
      vcnt_q        <= '0;
      vw_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      brcnt_q       <= '0;
      act_width_q   <= '0;
      act_height_q  <= '0;
      frame_ok_q    <= 1'b0;
      locked_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      frame_start_q <= 1'b0;
      err_flags_q   <= '0;
      err_count_q   <= '0;
      clr_pend_q    <= 1'b0;
`ifdef VGA_MON_ACT_CHECK_EN
      ref_w_q       <= '0;
      ref_vld_q     <= 1'b0;
`endif
    end else begin
      clr_pend_q <= clr_pend_d;
      if (mon.pix_en) begin
        state_q       <= state_d;
        hs_s_q        <= mon.hsync_in;
        vs_s_q        <= mon.vsync_in;
        br_s_q        <= mon.bright_in;
        hs_p_q        <= hs_s_q;
        vs_p_q        <= vs_s_q;
        br_p_q        <= br_s_q;
        hcnt_q        <= hcnt_d;
        hw_q          <= hw_d;
        vcnt_q        <= vcnt_d;
        vw_q          <= vw_d;
        x_q           <= x_d;
        y_q           <= y_d;
        brcnt_q       <= brcnt_d;
        act_width_q   <= act_width_d;
        act_height_q  <= act_height_d;
        frame_ok_q    <= frame_ok_d;
        locked_q      <= locked_d;
        pixel_valid_q <= pixel_valid_d;
        frame_start_q <= frame_start_d;
        err_flags_q   <= err_flags_d;
        err_count_q   <= err_count_d;
`ifdef VGA_MON_ACT_CHECK_EN
        ref_w_q       <= ref_w_d;
        ref_vld_q     <= ref_vld_d;
`endif
      end
    end
  end

  assign mon.locked      = locked_q;
  assign mon.pixel_valid = pixel_valid_q;
  assign mon.x           = x_q;
  assign mon.y           = y_q;
  assign mon.frame_start = frame_start_q;
  assign mon.act_width   = act_width_q;
  assign mon.act_height  = act_height_q;
  assign mon.err_flags   = err_flags_q;
  assign mon.err_count   = err_count_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down raster (32x16 total, 20x12 active).
module tb_vga_timing_monitor;
  localparam int HT = 32, HS = 4, VT = 16, VS = 2;
  localparam int BR_X0 = 8, BR_W = 20, BR_Y0 = 3, BR_H = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_timing_monitor_if mif();
  vga_timing_monitor #(.H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS)) dut (
    .clk(clk), .reset(reset), .mon(mif.slave)
  );

  logic [55:0] outs;
  assign outs = {mif.locked, mif.pixel_valid, mif.x, mif.y, mif.frame_start,
                 mif.act_width, mif.act_height, mif.err_flags, mif.err_count};

  int tests = 0, fails = 0;
  int div = 4;
  bit mon_en = 1'b0;
  int max_x = -1, max_y = -1, fs_cnt = 0, hold_bad = 0;
  logic [55:0] snap;

  task automatic strobe();
    mif.pix_en = 1'b1;
    @(posedge clk); #1;
    snap = outs;
    if (mon_en) begin
      if (mif.pixel_valid) begin
        if (int'(mif.x) > max_x) max_x = int'(mif.x);
        if (int'(mif.y) > max_y) max_y = int'(mif.y);
      end
      if (mif.frame_start) fs_cnt++;
    end
    mif.pix_en  = 1'b0;
    mif.err_clr = 1'b0;
    repeat (div - 1) begin
      @(posedge clk); #1;
      if (outs !== snap) hold_bad++;
    end
  endtask

  task automatic send_frame(input int nlines, input int vsw, input int sp_line, input int sp_len,
                            input int sp_hs, input int sp_br, input int clr_line);
    for (int l = 0; l < nlines; l++) begin
      int len, hsw, brw;
      len = HT;
      hsw = HS;
      brw = (l >= BR_Y0 && l < BR_Y0 + BR_H) ? BR_W : 0;
      if (l == sp_line) begin
        len = sp_len;
        hsw = sp_hs;
        brw = sp_br;
      end
      for (int p = 0; p < len; p++) begin
        mif.hsync_in  = (p < hsw) ? 1'b0 : 1'b1;
        mif.vsync_in  = (l < vsw) ? 1'b0 : 1'b1;
        mif.bright_in = (p >= BR_X0 && p < BR_X0 + brw) ? 1'b1 : 1'b0;
        mif.err_clr   = (l == clr_line && p == 10) ? 1'b1 : 1'b0;
        strobe();
      end
    end
  endtask

  task automatic clean_frame(input int clr_line);
    send_frame(VT, VS, -1, 0, 0, 0, clr_line);
  endtask

  task automatic test_reset();
    mif.pix_en = 1'b0; mif.hsync_in = 1'b1; mif.vsync_in = 1'b1;
    mif.bright_in = 1'b0; mif.err_clr = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (outs !== 56'd0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (outs !== 56'd0) begin fails++; $display("FAIL post_release_idle: got %h want 0", outs); end
  endtask

  task automatic test_nominal();
    div = 4;
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL nom_lock_frame1: got %0b want 0", mif.locked); end
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL nom_lock_frame2: got %0b want 1", mif.locked); end
    tests++; if (mif.act_width !== 10'd20) begin fails++; $display("FAIL nom_act_width: got %0d want 20", mif.act_width); end
    tests++; if (mif.act_height !== 10'd12) begin fails++; $display("FAIL nom_act_height: got %0d want 12", mif.act_height); end
    mon_en = 1'b1;
    clean_frame(-1);
    mon_en = 1'b0;
    tests++; if (max_x != 19) begin fails++; $display("FAIL nom_max_x: got %0d want 19", max_x); end
    tests++; if (max_y != 11) begin fails++; $display("FAIL nom_max_y: got %0d want 11", max_y); end
    tests++; if (fs_cnt != 1) begin fails++; $display("FAIL nom_frame_start_cnt: got %0d want 1", fs_cnt); end
    tests++; if (mif.err_flags !== 5'd0) begin fails++; $display("FAIL nom_err_flags: got %b want 00000", mif.err_flags); end
    tests++; if (mif.err_count !== 8'd0) begin fails++; $display("FAIL nom_err_count: got %0d want 0", mif.err_count); end
  endtask

  task automatic test_long_line();
    div = 2;
    send_frame(VT, VS, 1, HT + 1, HS, 0, -1);
    tests++; if (mif.err_flags !== 5'b00001) begin fails++; $display("FAIL long_line_flags: got %b want 00001", mif.err_flags); end
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL long_line_unlock: got %0b want 0", mif.locked); end
    tests++; if (mif.err_count !== 8'd1) begin fails++; $display("FAIL long_line_count: got %0d want 1", mif.err_count); end
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL relock_early: got %0b want 0", mif.locked); end
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL relock: got %0b want 1", mif.locked); end
  endtask

  task automatic test_short_sync();
    clean_frame(2);
    tests++; if (mif.err_flags !== 5'd0) begin fails++; $display("FAIL err_clr_1: got %b want 00000", mif.err_flags); end
    send_frame(VT, VS, 5, HT, HS - 1, BR_W, -1);
    tests++; if (mif.err_flags !== 5'b00010) begin fails++; $display("FAIL short_sync_flags: got %b want 00010", mif.err_flags); end
    tests++; if (mif.err_count !== 8'd2) begin fails++; $display("FAIL short_sync_count: got %0d want 2", mif.err_count); end
    clean_frame(8);
    tests++; if (mif.err_flags !== 5'd0) begin fails++; $display("FAIL err_clr_2: got %b want 00000", mif.err_flags); end
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL short_sync_relock: got %0b want 1", mif.locked); end
  endtask

  task automatic test_vertical();
    send_frame(VT + 1, VS, -1, 0, 0, 0, -1);
    clean_frame(-1);
    tests++; if (mif.err_flags !== 5'b00100) begin fails++; $display("FAIL long_frame_flags: got %b want 00100", mif.err_flags); end
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL long_frame_unlock: got %0b want 0", mif.locked); end
    clean_frame(4);
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL long_frame_relock: got %0b want 1", mif.locked); end
    send_frame(VT, VS + 1, -1, 0, 0, 0, -1);
    tests++; if (mif.err_flags !== 5'b01000) begin fails++; $display("FAIL vsync_width_flags: got %b want 01000", mif.err_flags); end
    tests++; if (mif.err_count !== 8'd4) begin fails++; $display("FAIL vsync_width_count: got %0d want 4", mif.err_count); end
  endtask

  task automatic test_narrow_line();
    clean_frame(4);
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL narrow_pre_lock: got %0b want 1", mif.locked); end
    send_frame(VT, VS, BR_Y0 + BR_H - 1, HT, HS, BR_W - 1, -1);
    tests++; if (mif.act_width !== 10'd19) begin fails++; $display("FAIL narrow_act_width: got %0d want 19", mif.act_width); end
`ifdef VGA_MON_ACT_CHECK_EN
    tests++; if (mif.err_flags !== 5'b10000) begin fails++; $display("FAIL narrow_flags: got %b want 10000", mif.err_flags); end
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL narrow_lock: got %0b want 0", mif.locked); end
`else
    tests++; if (mif.err_flags !== 5'b00000) begin fails++; $display("FAIL narrow_flags: got %b want 00000", mif.err_flags); end
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL narrow_lock: got %0b want 1", mif.locked); end
`endif
  endtask

  task automatic test_mid_reset();
    send_frame(8, VS, -1, 0, 0, 0, -1);
    reset = 1'b1;
    #1;
    tests++; if (outs !== 56'd0) begin fails++; $display("FAIL mid_reset_outputs: got %h want 0", outs); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b0) begin fails++; $display("FAIL mid_reset_lock1: got %0b want 0", mif.locked); end
    tests++; if (mif.err_count !== 8'd0) begin fails++; $display("FAIL mid_reset_count: got %0d want 0", mif.err_count); end
    clean_frame(-1);
    tests++; if (mif.locked !== 1'b1) begin fails++; $display("FAIL mid_reset_lock2: got %0b want 1", mif.locked); end
    tests++; if (mif.act_height !== 10'd12) begin fails++; $display("FAIL mid_reset_height: got %0d want 12", mif.act_height); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_long_line();
    test_short_sync();
    test_vertical();
    test_narrow_line();
    test_mid_reset();
    tests++; if (hold_bad != 0) begin fails++; $display("FAIL strobe_hold: got %0d changes want 0", hold_bad); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

- Receive-side counterpart of the VGA timing generator: samples `hsync_in`, `vsync_in` and `bright_in` on a pixel strobe.
- Recovers pixel coordinates and measures line, frame and active-window geometry.
- Checks the timing against expected parameters and reports lock and errors.
- Used as an on-chip monitor/capture front end and as the bench checker for the display path.

## Interface
- `H_TOTAL`, 800, expected pixels per line (hsync fall to hsync fall).
- `H_SYNC`, 96, expected hsync low width in pixels.
- `V_TOTAL`, 525, expected lines per frame (vsync fall to vsync fall).
- `V_SYNC`, 2, expected vsync low width in lines.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `pix_en` input 1: pixel strobe; all state advances only on `clk` edges with `pix_en`=1.
- `hsync_in` input 1: horizontal sync, active low.
- `vsync_in` input 1: vertical sync, active low.
- `bright_in` input 1: active-video flag.
- `err_clr` input 1: one-cycle pulse that clears `err_flags`.
- `locked` output 1: timing verified for a full frame.
- `pixel_valid` output 1: `locked` and the sample was bright.
- `x` output 10: active pixel column.
- `y` output 10: active line index.
- `frame_start` output 1: one-strobe pulse on vsync fall.
- `act_width` output 10: last measured active width.
- `act_height` output 10: last measured active height.
- `err_flags` output 5: sticky error bits. [0] H_PERIOD, [1] H_WIDTH, [2] V_PERIOD, [3] V_WIDTH, [4] ACT_WIDTH.
- `err_count` output 8: lock losses, saturating at 255.

## Operation
- **Input stage:** inputs are registered on each strobe (sample k). Edges are detected against sample k-1.
- **Horizontal counter:**
  - `hcnt` (10 b) resets to 0 on an hsync-fall sample; otherwise it increments, saturating at 1023.
  - At an hsync fall, the measured period is previous `hcnt`+1; a mismatch with `H_TOTAL` flags H_PERIOD.
  - `hcnt` reaching 1023 also flags H_PERIOD.
  - Hsync low samples are counted; at hsync rise, a mismatch with `H_SYNC` flags H_WIDTH.
- **Vertical counter:**
  - `vcnt` (10 b, saturating) resets to 0 on a vsync-fall sample and increments on other hsync-fall samples.
  - At a vsync fall, `vcnt`+1 ≠ `V_TOTAL` flags V_PERIOD.
  - Vsync low width is counted in lines: it is 1 at the vsync fall and increments on each later hsync fall while vsync is low.
  - A vsync rise coincident with an hsync fall is not counted. At vsync rise, a mismatch with `V_SYNC` flags V_WIDTH.
- **Active window:**
  - `x` is 0 on the first bright sample of a line and increments per bright sample.
  - `y` is 0 on the first line of the frame containing bright and increments per further bright line.
  - At bright fall, `act_width` ← `x`+1.
  - At vsync fall, `act_height` ← bright-line count, and that count is cleared.
- **States:**
  - SEEK: errors ignored. Vsync fall → ACQ.
  - ACQ: any error clears the frame-ok flag. At vsync fall: frame ok → LOCKED; otherwise stay in ACQ with the flag re-armed.
  - LOCKED: any error → SEEK, the error bit is set, and `err_count` increments.
- **Error flags:** bits are set only in ACQ/LOCKED. `err_clr` clears them; a set in the same cycle as `err_clr` wins.
- **Coincident edges:** when hsync fall and vsync fall occur on the same sample, the line measurement is taken first, then the frame measurement.

## Timing
- **Reset values:** all outputs 0; state SEEK; counters 0; edge history registers 1 (sync idle high).
- **Output latency:** outputs for sample k are registered on strobe k+1, i.e. one pixel period.
- **Lock:**
  - `locked` rises on the strobe after the second vsync fall following reset, given clean timing.
  - `locked` falls on the strobe after the erroring sample.
- **`frame_start`:** high for exactly one strobe period.
- **Mid-operation reset:** returns immediately to the reset values; no partial measurement survives.
- **Strobe gating:** `pix_en`=0 holds all state, including pulse outputs.

## Configuration
- `VGA_MON_ACT_CHECK_EN` defined:
  - In ACQ/LOCKED, every active line's width must equal the first active line's width in that frame.
  - A mismatch sets ACT_WIDTH and counts as an error.
- Undefined: no width-consistency logic; `err_flags[4]` is tied 0. `act_width`/`act_height` are still reported.

## Test plan
- **Nominal:** 800/96 h, 525/2 v, bright 640×480, `pix_en` every 4th clk → `locked`=1 after the second vsync fall; `act_width`=640, `act_height`=480; max `x`=639, max `y`=479; `err_flags`=0.
- **Long line:** one 801-pixel line while locked → `err_flags`=5'b00001, `locked`=0, `err_count`=1; relock after two further clean vsync falls.
- **Short sync:** hsync low 95 while locked → `err_flags[1]`=1. Then `err_clr` → `err_flags`=0.
- **Long frame:** 526-line frame while locked → `err_flags[2]`=1. Separately, vsync low 3 lines → `err_flags[3]`=1.
- **Narrow line:** one active line of 639 pixels → with the macro, `err_flags[4]`=1 and `locked` drops; without the macro, `locked` stays 1 and `act_width` is 639 after that line.
- **Mid-frame reset:** `reset` at `vcnt`=200 → all outputs 0 immediately; `locked` returns only after two vsync falls post-release.
